freq_bin_shifter: RTL

FREQ_BIN_SHIFTER -- requirements
Module: freq_bin_shifter

---
 rtl/freq_bin_shifter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/freq_bin_shifter.sv
// ============================================================================
// Module   : freq_bin_shifter
// Captures one FFT frame into block RAM, then replays it with a pitch shift
// across bins and conjugate-symmetric mirroring.
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_bin_shifter #(
  parameter int FRAME_LENTH = 1024,
  parameter int SCALE_SHIFT = 10
) (
  input  logic        i_aclk,
  input  logic        rst_n,
  input  logic [4:0]  current_state,
  input  logic        i_axi4s_data_tvalid,
  input  logic [63:0] i_axi4s_data_tdata,
  input  logic        i_axi4s_data_tlast,
  input  logic [7:0]  shift_cfg,
  output logic [31:0] freq_data,
  output logic        freq_valid,
  output logic        freq_last,
  output logic        frame_err
);

  localparam int AW = $clog2(FRAME_LENTH);
  // Signed index width must hold k, N-k and the full +/-128 shift range.
  localparam int SW = ((AW > 8) ? AW : 8) + 2;

  localparam logic [4:0] c_S0 = 5'b00001;
  localparam logic [4:0] c_S2 = 5'b00100;
  localparam logic [4:0] c_S3 = 5'b01000;

  localparam logic [AW-1:0]        c_LAST_ADDR = AW'(FRAME_LENTH - 1);
  localparam logic signed [SW-1:0] c_N         = SW'(FRAME_LENTH);
  localparam logic signed [SW-1:0] c_H         = SW'(FRAME_LENTH / 2);
  localparam logic signed [SW-1:0] c_ONE       = SW'(1);
  localparam logic signed [SW-1:0] c_ZERO      = SW'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2,
    PLAY    = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_rd_idx;
  logic [7:0]    r_shift_q;

  logic          w_wr_en;
  logic          w_err;
  logic          w_at_end;
  logic [31:0]   w_wr_data;

  logic signed [SW-1:0] w_k, w_shift, w_base, w_src;
  logic                 w_zero, w_conj, w_issue;
  logic [AW-1:0]        w_rd_addr;

  logic [31:0] r_ram [FRAME_LENTH];
  logic [31:0] r_ram_q;
  logic        r_v1, r_last1, r_zero1, r_conj1;

  function automatic logic [15:0] f_trunc(input logic signed [31:0] x);
    logic signed [31:0] s;
    s = x >>> SCALE_SHIFT;
    if (s > 32'sd32767)
      return 16'h7FFF;
    else if (s < -32'sd32768)
      return 16'h8000;
    else
      return 16'(s);
  endfunction

  function automatic logic [15:0] f_neg(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7FFF : (~x + 16'd1);
  endfunction

  assign w_at_end  = (r_wr_addr == c_LAST_ADDR);
  assign w_wr_data = {f_trunc(i_axi4s_data_tdata[63:32]), f_trunc(i_axi4s_data_tdata[31:0])};

  always_comb begin
    w_next  = r_state;
    w_wr_en = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (current_state == c_S2) w_next = CAPTURE;
      end
      CAPTURE: begin
        // An abort wins over a beat arriving in the same cycle.
        if (current_state == c_S0) begin
          w_next = IDLE;
        end else if (i_axi4s_data_tvalid) begin
          w_wr_en = 1'b1;
          if (i_axi4s_data_tlast || w_at_end) begin
            w_next = FULL;
            w_err  = i_axi4s_data_tlast ^ w_at_end;
          end
        end
      end
      FULL: begin
        if (current_state == c_S3) w_next = PLAY;
      end
      PLAY: begin
        if (r_rd_idx == c_LAST_ADDR) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wr_addr <= '0;
      r_rd_idx  <= '0;
      r_shift_q <= '0;
      frame_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      frame_err <= w_err;
      if (r_state == IDLE)
        r_wr_addr <= '0;
      else if (w_wr_en)
        r_wr_addr <= r_wr_addr + AW'(1);
      if (r_state == FULL && w_next == PLAY) begin
        r_shift_q <= shift_cfg;
        r_rd_idx  <= '0;
      end else if (r_state == PLAY) begin
        r_rd_idx  <= r_rd_idx + AW'(1);
      end
    end
  end

  // Source bin for the issued index; upper half mirrors the lower half.
  always_comb begin
    w_issue   = (r_state == PLAY);
    w_k       = $signed({{(SW-AW){1'b0}}, r_rd_idx});
    w_shift   = $signed({{(SW-8){r_shift_q[7]}}, r_shift_q});
    w_base    = (w_k > c_H) ? (c_N - w_k) : w_k;
    w_src     = w_base - w_shift;
    w_conj    = (w_k > c_H);
    w_zero    = (w_k == c_H) ||
                ((w_k != c_ZERO) && ((w_src < c_ONE) || (w_src >= c_H)));
    w_rd_addr = (w_k == c_ZERO) ? '0 : AW'(w_src);
  end

  always_ff @(posedge i_aclk) begin
    if (w_wr_en) r_ram[r_wr_addr] <= w_wr_data;
    r_ram_q <= r_ram[w_rd_addr];
  end

  always_ff @(posedge i_aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1       <= 1'b0;
      r_last1    <= 1'b0;
      r_zero1    <= 1'b0;
      r_conj1    <= 1'b0;
      freq_data  <= '0;
      freq_valid <= 1'b0;
      freq_last  <= 1'b0;
    end else begin
      r_v1       <= w_issue;
      r_last1    <= w_issue && (r_rd_idx == c_LAST_ADDR);
      r_zero1    <= w_zero;
      r_conj1    <= w_conj;
      freq_valid <= r_v1;
      freq_last  <= r_last1;
      if (!r_v1 || r_zero1)
        freq_data <= '0;
      else if (r_conj1)
        freq_data <= {f_neg(r_ram_q[31:16]), r_ram_q[15:0]};
      else
        freq_data <= r_ram_q;
    end
  end

endmodule

`default_nettype wire
